scan_seq_array: RTL

Parametrised array of CH identical three-flop sequential channels sharing one scan chain, with a built-in scan controller. It sits in the test-structure stage of the design as the scan-inserted, multi-channel successor to the single hand-built three-flop circuit. A bench can serially load state, run one functional capture cycle, and unload the result. An optional MISR compacts the unloaded bits.

---
 rtl/scan_seq_array.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/scan_seq_array.sv
// -----------------------------------------------------------------------------
// scan_seq_array
//
// Purpose:
//   An array of CH identical three-flop sequential channels (Q1, Q2, Q3)
//   stitched into one scan chain. A built-in controller serially loads the
//   chain, runs exactly one functional capture cycle, and then returns to
//   idle. The captured state is unloaded during the next scan sequence.
//   An optional 16-bit MISR compacts the bits unloaded during a scan.
//
// Build option:
//   SCAN_MISR_EN - when defined, adds the 16-bit MISR (polynomial 0x1021)
//                  on the unloaded scan stream. When undefined, misr is a
//                  constant 16'h0000 and no MISR logic is built.
//
// Parameters:
//   CH           - number of channels; the chain length is L = 3*CH.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   a, b, c, d   - per-channel functional inputs (bit i feeds channel i)
//   func_en      - in IDLE: 1 = functional load every cycle, 0 = hold
//   scan_req     - starts a scan sequence (sampled in IDLE only)
//   scan_in      - serial scan data into ch0.Q1
//   y            - per-channel combinational output
//   scan_out     - serial scan data out of ch(CH-1).Q3
//   busy         - high while shifting or capturing
//   scan_done    - one-cycle pulse after the capture
//   misr         - signature of the bits unloaded during the last scan
//
// Chain order:
//   scan_in -> ch0.Q1 -> ch0.Q2 -> ch0.Q3 -> ch1.Q1 -> ... -> ch(CH-1).Q3
//   r_chain[3*i+0] = ch i Q1, r_chain[3*i+1] = Q2, r_chain[3*i+2] = Q3.
// -----------------------------------------------------------------------------
module scan_seq_array #(
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] a,
    input  logic [CH-1:0] b,
    input  logic [CH-1:0] c,
    input  logic [CH-1:0] d,
    input  logic          func_en,
    input  logic          scan_req,
    input  logic          scan_in,
    output logic [CH-1:0] y,
    output logic          scan_out,
    output logic          busy,
    output logic          scan_done,
    output logic [15:0]   misr
);

    localparam int L  = 3 * CH;
    localparam int CW = $clog2(L + 1);

    // Counter value seen on the edge that performs the L-th shift.
    localparam logic [CW-1:0] LAST_SHIFT = CW'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    logic [L-1:0]    r_chain;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_scan_done;

    logic [L-1:0]    w_func_next;
    logic [L-1:0]    w_shift_next;

    // -------------------------------------------------------------------------
    // Per-channel functional logic. Each channel reads its three flops from
    // the shared chain vector and produces its functional next state and y.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic w_q1;
            logic w_q2;
            logic w_q3;
            logic w_n3;
            logic w_n_and;
            logic w_n4;

            assign w_q1    = r_chain[3*gi];
            assign w_q2    = r_chain[3*gi+1];
            assign w_q3    = r_chain[3*gi+2];

            assign w_n3    = ~(a[gi] | w_q2);
            assign w_n_and = ~d[gi] & w_q3;
            assign w_n4    = ~(w_q1 | ~((w_n3 | w_n_and) & (c[gi] | w_n_and)));

            assign w_func_next[3*gi]   = d[gi] & ~w_n4;
            assign w_func_next[3*gi+1] = ~(b[gi] | w_n3);
            assign w_func_next[3*gi+2] = w_n4;

            // With all flops cleared by reset this reduces to a | ~c.
            assign y[gi] = ~w_n4;
        end
    endgenerate

    // One position towards scan_out per shift; scan_in enters at ch0.Q1.
    assign w_shift_next = {r_chain[L-2:0], scan_in};

    // -------------------------------------------------------------------------
    // Scan controller and chain state. busy/scan_done are registered and
    // updated alongside the state so they line up with the state exactly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_chain     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_scan_done <= 1'b0;
                    if (func_en) begin
                        r_chain <= w_func_next;
                    end
                    if (scan_req) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_chain <= w_shift_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_SHIFT) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Capture ignores func_en: the scan always gets one load.
                    r_chain     <= w_func_next;
                    r_state     <= S_DONE;
                    r_busy      <= 1'b0;
                    r_scan_done <= 1'b1;
                end
                S_DONE: begin
                    r_scan_done <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_scan_done <= 1'b0;
                end
            endcase
        end
    end

    assign scan_out  = r_chain[L-1];
    assign busy      = r_busy;
    assign scan_done = r_scan_done;

    // -------------------------------------------------------------------------
    // Optional signature register over the unloaded stream. It folds in the
    // bit presented on scan_out just before each shift edge.
    // -------------------------------------------------------------------------
`ifdef SCAN_MISR_EN
    logic [15:0] r_misr;
    logic [15:0] w_misr_next;

    assign w_misr_next = {r_misr[14:0], 1'b0}
                       ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                       ^ {15'b0, r_chain[L-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misr <= 16'h0000;
        end else if (r_state == S_IDLE && scan_req) begin
            r_misr <= 16'h0000;
        end else if (r_state == S_SHIFT) begin
            r_misr <= w_misr_next;
        end
    end

    assign misr = r_misr;
`else
    assign misr = 16'h0000;
`endif

endmodule
